mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one byte-wide, single-port unified memory between the core's instruction-fetch port and its data (LB/SB) port.
- The fetch port receives a 32-bit word assembled from four sequential byte reads.
- The data port receives single-byte reads and writes.
- Sits between the pipelined core and the memory macro; the core stalls on a requester until that requester's grant and response arrive.

Parameters:
- ADDR_W, 8, address width of both ports and the memory.
- DATA_W, 8, memory data width (byte).
- FETCH_BYTES, 4, bytes per instruction fetch; i_rdata width is DATA_W*FETCH_BYTES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch byte address; sampled at i_gnt.
- i_gnt  out  1  one-cycle fetch accept pulse.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetched word, big-endian: byte at i_addr goes to [31:24].
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read; sampled at d_gnt.
- d_addr  in  ADDR_W  data address; sampled at d_gnt.
- d_wdata  in  DATA_W  write data; sampled at d_gnt.
- d_gnt  out  1  one-cycle data accept pulse.
- d_rvalid  out  1  one-cycle pulse; read data valid or write done.
- d_rdata  out  DATA_W  read byte; 0 after writes.
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_re.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE.
  - All outputs 0; beat counter 0; last_grant = DATA, so fetch wins the first tie.
  - In-flight transactions are discarded; no rvalid is issued for them.
- FSM states: IDLE, FETCH, DREAD, DWRITE, RESP.
- Grants are given only in IDLE.
  - gnt is combinational from req and the FSM state; the address/data capture is registered on the same edge.
- Arbitration in IDLE:
  - Only one requester active: that requester is granted.
  - Both active: round-robin; the requester not in last_grant wins, and last_grant is updated.
- FETCH:
  - Cycles G+1..G+4 drive mem_re=1, mem_addr = i_addr+k for k=0..3, mod 2^ADDR_W (wraps 0xFF->0x00).
  - Returned bytes are shifted into the word register at G+2..G+5.
  - Then RESP: i_rvalid=1 at G+6, and the FSM returns to IDLE that cycle.
- DREAD: mem_re at G+1, data captured at G+2, RESP with d_rvalid at G+3.
- DWRITE: mem_we=1 with mem_addr/mem_wdata at G+1, d_rvalid at G+2.
- Between transactions, mem_addr and mem_wdata are 0 and mem_re/mem_we are 0.
- No two grants occur within one transaction.
  - The earliest next grant is the RESP cycle, since IDLE is decided combinationally on exit from RESP.
- i_rdata and d_rdata hold their value until the next rvalid of the same port.
- A req deasserted before gnt is legal; the request is dropped.
- A req deasserted after gnt has no effect on the transaction.
- A requester may re-request in its rvalid cycle.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
  - Defined: data port always wins ties; last_grant is unused.
  - Undefined: round-robin as above.
- Latencies are unchanged in both cases.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum;
  - the GRANT_I/GRANT_D encoding;
  - latency constants FETCH_LAT=6, DREAD_LAT=3, DWRITE_LAT=2.
- One natural sub-module, mem_arb_fetch_pack: beat counter plus byte shift register producing the big-endian word and a last-beat flag.

Test Plan:
- Fetch only: mem bytes 0x10..0x13 = 20,01,00,05; i_req, i_addr=0x10 -> i_gnt at G, mem_re G+1..G+4 with addr 10..13, i_rvalid at G+6 with i_rdata=0x20010005.
- Wrap: i_addr=0xFE -> mem_addr sequence FE,FF,00,01; word assembled in that order.
- Data write then read: write 0xA5 to 0x40 -> mem_we at G+1, d_rvalid at G+2; read 0x40 -> d_rvalid at G+3 with d_rdata=0xA5.
- Contention: i_req and d_req held continuously from reset -> grants alternate I,D,I,D (macro undefined); with ARB_FIXED_PRIO_EN -> D granted every time, I never granted.
- Reset mid-fetch: assert rst at G+3 -> all outputs 0 immediately; no i_rvalid afterwards; new fetch after release completes in 6 cycles.
- Request withdrawn: d_req pulsed one cycle while a fetch is busy -> no d_gnt, no memory write.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DREAD  = 3'd2,
    DWRITE = 3'd3,
    RESP   = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Cycles from grant to the rvalid pulse of each transaction type.
  localparam int unsigned FETCH_LAT  = 32'd6;
  localparam int unsigned DREAD_LAT  = 32'd3;
  localparam int unsigned DWRITE_LAT = 32'd2;

endpackage

// File: rtl/mem_arb_fetch_pack.sv
// Collects sequential fetch bytes into a big-endian word; first byte lands in the top lane.
module mem_arb_fetch_pack #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          shift_i,
  input  logic [DATA_W-1:0]             byte_i,
  output logic [DATA_W*FETCH_BYTES-1:0] word_o,
  output logic                          last_o
);

  localparam int unsigned WORD_W = DATA_W * FETCH_BYTES;
  localparam int unsigned CNT_W  = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FETCH_BYTES - 1);

  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] shifted_s;

  // Beat counter and shift register next-state.
  always_comb begin
    shifted_s = {word_q[WORD_W-DATA_W-1:0], byte_i};
    beat_d    = beat_q;
    word_d    = word_q;
    if (start_i) begin
      beat_d = {CNT_W{1'b0}};
      word_d = {WORD_W{1'b0}};
    end else if (shift_i) begin
      beat_d = (beat_q == LAST_BEAT) ? {CNT_W{1'b0}} : beat_q + CNT_W'(1);
      word_d = shifted_s;
    end else begin
      beat_d = beat_q;
      word_d = word_q;
    end
  end

  // Pack state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= {CNT_W{1'b0}};
      word_q <= {WORD_W{1'b0}};
    end else begin
      beat_q <= beat_d;
      word_q <= word_d;
    end
  end

  // The word including the byte arriving this cycle, valid when last_o is high.
  assign word_o = shifted_s;
  assign last_o = shift_i && (beat_q == LAST_BEAT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide single-port memory between a 4-byte fetch port and a byte data port.
// Tie policy is round-robin unless ARB_FIXED_PRIO_EN is defined (data port then always wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          i_gnt,
  output logic                          i_rvalid,
  output logic [DATA_W*FETCH_BYTES-1:0] i_rdata,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int unsigned WORD_W = DATA_W * FETCH_BYTES;
  localparam int unsigned ISS_W  = $clog2(FETCH_BYTES) + 1;
  localparam logic [ISS_W-1:0] ISS_MAX = ISS_W'(FETCH_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ISS_W-1:0]  iss_q, iss_d;
  logic              rd_pend_q, rd_pend_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef ARB_FIXED_PRIO_EN
`else
  grant_e            last_grant_q, last_grant_d;
`endif

  logic              can_grant_s;
  logic              pick_d_s;
  logic              gnt_i_s;
  logic              gnt_d_s;
  logic              fetch_shift_s;
  logic              fetch_last_s;
  logic [WORD_W-1:0] fetch_word_s;

  // Grant decision; grants are suppressed while reset is asserted so all outputs read 0.
  always_comb begin
    can_grant_s = rst && ((state_q == IDLE) || (state_q == RESP));
    if (i_req && d_req) begin
`ifdef ARB_FIXED_PRIO_EN
      pick_d_s = 1'b1;
`else
      pick_d_s = (last_grant_q == GRANT_I);
`endif
    end else begin
      pick_d_s = d_req;
    end
    gnt_i_s = can_grant_s && i_req && !pick_d_s;
    gnt_d_s = can_grant_s && d_req && pick_d_s;
  end

  assign fetch_shift_s = (state_q == FETCH) && rd_pend_q;

  mem_arb_fetch_pack #(
    .DATA_W      (DATA_W),
    .FETCH_BYTES (FETCH_BYTES)
  ) u_pack (
    .clk     (clk),
    .rst     (rst),
    .start_i (gnt_i_s),
    .shift_i (fetch_shift_s),
    .byte_i  (mem_rdata),
    .word_o  (fetch_word_s),
    .last_o  (fetch_last_s)
  );

  // Next state and next registered outputs; memory strobes default low and buses to zero.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    iss_d       = iss_q;
    rd_pend_d   = mem_re_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_FIXED_PRIO_EN
`else
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (gnt_i_s) begin
          state_d    = FETCH;
          addr_d     = i_addr;
          iss_d      = ISS_W'(1);
          mem_re_d   = 1'b1;
          mem_addr_d = i_addr;
`ifdef ARB_FIXED_PRIO_EN
`else
          last_grant_d = GRANT_I;
`endif
        end else if (gnt_d_s) begin
          mem_addr_d = d_addr;
`ifdef ARB_FIXED_PRIO_EN
`else
          last_grant_d = GRANT_D;
`endif
          if (d_we) begin
            state_d     = DWRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = d_wdata;
          end else begin
            state_d  = DREAD;
            mem_re_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (iss_q < ISS_MAX) begin
          mem_re_d   = 1'b1;
          mem_addr_d = addr_q + ADDR_W'(iss_q);
          iss_d      = iss_q + ISS_W'(1);
        end else begin
          iss_d = iss_q;
        end
        if (fetch_last_s) begin
          state_d    = RESP;
          i_rvalid_d = 1'b1;
          i_rdata_d  = fetch_word_s;
        end else begin
          state_d = FETCH;
        end
      end
      DREAD: begin
        if (rd_pend_q) begin
          state_d    = RESP;
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_rdata;
        end else begin
          state_d = DREAD;
        end
      end
      DWRITE: begin
        state_d    = RESP;
        d_rvalid_d = 1'b1;
        d_rdata_d  = {DATA_W{1'b0}};
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      iss_q       <= {ISS_W{1'b0}};
      rd_pend_q   <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= {WORD_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
`ifdef ARB_FIXED_PRIO_EN
`else
      last_grant_q <= GRANT_D;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_q       <= iss_d;
      rd_pend_q   <= rd_pend_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_FIXED_PRIO_EN
`else
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign i_gnt     = gnt_i_s;
  assign d_gnt     = gnt_d_s;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus random bench for mem_arbiter with a byte memory and a reference memory image.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [7:0]  d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [7:0]  d_rdata;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic        preload;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          model_last;      // port of the most recent grant, 1 = data
  logic [31:0] last_iw;
  logic [7:0]  last_db;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read byte memory; preload copies the reference image in one cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [31:0] w;
    logic [7:0]  ak;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ak = a + 8'(k);
      w  = {w[23:0], ref_mem[ak]};
    end
    return w;
  endfunction

  function automatic bit tie_winner(input bit last_d);
`ifdef ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return !last_d;
`endif
  endfunction

  // Called right after driving a request at a falling edge; returns in the grant cycle.
  task automatic wait_gnt(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if ((is_d ? d_gnt : i_gnt) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("gnt_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_fetch(input logic [7:0] a, input bit poke_d);
    logic [31:0] exp_w;
    logic [7:0]  ak;
    bit          ok;
    exp_w  = word_at(a);
    i_req  = 1'b1;
    i_addr = a;
    wait_gnt(1'b0, ok);
    if (!ok) begin
      i_req = 1'b0;
      return;
    end
    model_last = 1'b0;
    for (int k = 1; k <= FETCH_LAT; k++) begin
      @(negedge clk);
      i_req  = 1'b0;
      i_addr = 8'($urandom);
      ak     = a + 8'(k - 1);
      check("fetch_re", 32'(mem_re), 32'(k <= 4));
      check("fetch_addr", 32'(mem_addr), (k <= 4) ? 32'(ak) : 32'd0);
      check("fetch_we", 32'(mem_we), 32'd0);
      check("fetch_rvalid", 32'(i_rvalid), 32'(k == FETCH_LAT));
      if (poke_d && k == 2) begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h77; d_wdata = 8'h5A;
        #1;
        check("withdraw_gnt", 32'(d_gnt), 32'd0);
      end else begin
        d_req = 1'b0;
      end
    end
    check("fetch_word", i_rdata, exp_w);
    check("fetch_dhold", 32'(d_rdata), 32'(last_db));
    last_iw = exp_w;
  endtask

  task automatic do_read(input logic [7:0] a);
    bit ok;
    d_req = 1'b1; d_we = 1'b0; d_addr = a; d_wdata = 8'($urandom);
    wait_gnt(1'b1, ok);
    if (!ok) begin
      d_req = 1'b0;
      return;
    end
    model_last = 1'b1;
    for (int k = 1; k <= DREAD_LAT; k++) begin
      @(negedge clk);
      d_req = 1'b0; d_addr = 8'($urandom); d_we = 1'($urandom);
      check("rd_re", 32'(mem_re), 32'(k == 1));
      check("rd_addr", 32'(mem_addr), (k == 1) ? 32'(a) : 32'd0);
      check("rd_we", 32'(mem_we), 32'd0);
      check("rd_rvalid", 32'(d_rvalid), 32'(k == DREAD_LAT));
    end
    check("rd_data", 32'(d_rdata), 32'(ref_mem[a]));
    check("rd_ihold", i_rdata, last_iw);
    last_db = ref_mem[a];
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] w);
    bit ok;
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = w;
    wait_gnt(1'b1, ok);
    if (!ok) begin
      d_req = 1'b0;
      return;
    end
    model_last = 1'b1;
    for (int k = 1; k <= DWRITE_LAT; k++) begin
      @(negedge clk);
      d_req = 1'b0; d_addr = 8'($urandom); d_wdata = 8'($urandom); d_we = 1'($urandom);
      check("wr_we", 32'(mem_we), 32'(k == 1));
      check("wr_addr", 32'(mem_addr), (k == 1) ? 32'(a) : 32'd0);
      check("wr_wdata", 32'(mem_wdata), (k == 1) ? 32'(w) : 32'd0);
      check("wr_re", 32'(mem_re), 32'd0);
      check("wr_rvalid", 32'(d_rvalid), 32'(k == DWRITE_LAT));
    end
    check("wr_rdata", 32'(d_rdata), 32'd0);
    ref_mem[a] = w;
    last_db    = 8'h00;
  endtask

  // Both ports request continuously; grants must follow the tie policy.
  task automatic tie_run(input int n);
    logic [7:0] ia, da;
    int         seen;
    bit         got_i, got_d;
    ia = 8'($urandom); da = 8'($urandom);
    i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
    seen = 0; got_i = 1'b0; got_d = 1'b0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      #1;
      if (i_gnt || d_gnt) begin
        check("tie_both", 32'(i_gnt && d_gnt), 32'd0);
        check("tie_winner", 32'(d_gnt), 32'(tie_winner(model_last)));
        model_last = d_gnt;
        got_i |= i_gnt;
        got_d |= d_gnt;
        seen++;
      end
      @(negedge clk);
    end
    check("tie_count", 32'(seen), 32'(n));
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) @(negedge clk);
    if (got_i) last_iw = word_at(ia);
    if (got_d) last_db = ref_mem[da];
    check("tie_ihold", i_rdata, last_iw);
    check("tie_dhold", 32'(d_rdata), 32'(last_db));
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] w;
    bit         ok;
    bit         seen_rv;

    rst = 1'b0; preload = 1'b1;
    i_req = 1'b0; i_addr = 8'h00; d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    model_last = 1'b1; last_iw = 32'h0; last_db = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h10] = 8'h20; ref_mem[8'h11] = 8'h01; ref_mem[8'h12] = 8'h00; ref_mem[8'h13] = 8'h05;
    ref_mem[8'hFE] = 8'h11; ref_mem[8'hFF] = 8'h22; ref_mem[8'h00] = 8'h33; ref_mem[8'h01] = 8'h44;
    @(negedge clk);
    preload = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    #1;
    check("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("rst_irdata", i_rdata, 32'd0);
    check("rst_drdata", 32'(d_rdata), 32'd0);
    check("rst_mem", {14'd0, mem_re, mem_we, mem_addr, mem_wdata}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    tie_run(4);

    do_fetch(8'h10, 1'b0);
    check("fetch_plan_word", last_iw, 32'h20010005);
    do_fetch(8'hFE, 1'b0);
    check("wrap_word", i_rdata, 32'h11223344);
    do_write(8'h40, 8'hA5);
    do_read(8'h40);
    check("wr_rd_A5", 32'(d_rdata), 32'h000000A5);

    do_fetch(8'h10, 1'b1);
    check("withdraw_mem", 32'(mem[8'h77]), 32'(ref_mem[8'h77]));
    do_read(8'h77);

    // Reset asserted three cycles into a fetch.
    i_req = 1'b1; i_addr = 8'h30;
    wait_gnt(1'b0, ok);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("rstmid_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("rstmid_irdata", i_rdata, 32'd0);
    check("rstmid_drdata", 32'(d_rdata), 32'd0);
    check("rstmid_mem", {14'd0, mem_re, mem_we, mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    i_req = 1'b0;
    rst = 1'b1;
    model_last = 1'b1; last_iw = 32'h0; last_db = 8'h00;
    seen_rv = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (i_rvalid !== 1'b0) seen_rv = 1'b1;
    end
    check("rstmid_no_rvalid", 32'(seen_rv), 32'd0);
    do_fetch(8'h10, 1'b0);

    for (int t = 0; t < 40; t++) begin
      a = 8'($urandom);
      w = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       do_fetch(a, 1'b0);
        1:       do_read(a);
        default: do_write(a, w);
      endcase
    end
    tie_run(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
